// File: rtl/multi_rate_coder_pkg.sv
// Shared definitions for the spike rate coders.
// Contents: coder FSM state enum, LFSR width and tap mask, seed-mix constant,
// and chan_seed(), which derives each channel's non-zero LFSR seed from a base.
package snn_coder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned LFSR_W = 16;
  // Feedback taps: bits 15, 13, 12, 10 (x^16 + x^14 + x^13 + x^11 + 1).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_MIX  = 16'h9E37;

  // Per-channel seed. A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned i);
    logic [31:0] prod;
    logic [15:0] s;
    prod = i * 32'(SEED_MIX);
    s    = base ^ prod[15:0];
    if (s == '0) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/multi_rate_coder_if.sv
// Frame-in / spike-out bundle for multi_rate_coder.
// Signals: in_valid, in_ready, in_data (N_CH*W, channel i at [i*W +: W]),
// spikes (N_CH), spike_valid, step_idx ($clog2(T_STEPS)), done.
// With MULTI_RATE_CODER_SPIKE_COUNT_EN defined the bundle also carries
// spike_count (N_CH * $clog2(T_STEPS+1)).
// Modports: master = frame source / spike sink, slave = the coder.
interface multi_rate_coder_if #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned W       = 16,
  parameter int unsigned T_STEPS = 64
);
  localparam int unsigned SW = $clog2(T_STEPS);

  logic              in_valid;
  logic              in_ready;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   spikes;
  logic              spike_valid;
  logic [SW-1:0]     step_idx;
  logic              done;

`ifdef MULTI_RATE_CODER_SPIKE_COUNT_EN
  localparam int unsigned CW = $clog2(T_STEPS + 1);
  logic [N_CH*CW-1:0] spike_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, spikes, spike_valid, step_idx, done, spike_count
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, spikes, spike_valid, step_idx, done, spike_count
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready, spikes, spike_valid, step_idx, done
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, spikes, spike_valid, step_idx, done
  );
`endif

endinterface

// File: rtl/multi_rate_coder_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, left shift, maximal length (period 65535).
// Ports: clk, rst (async, active-low, loads SEED), en (advance one step),
// q[15:0] current state.
module lfsr16
  import snn_coder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  always_comb fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/multi_rate_coder.sv
// multi_rate_coder: N_CH-channel Poisson-style rate encoder. One frame of
// intensities is accepted per window and presented for T_STEPS cycles;
// channel i spikes when its intensity exceeds the top W bits of its own LFSR.
// Ports: clk, rst (async, active-low), bus (multi_rate_coder_if.slave:
// in_valid/in_ready/in_data frame handshake; spikes/spike_valid/step_idx
// registered spike stream; done one-cycle end-of-window pulse).
// Option: MULTI_RATE_CODER_SPIKE_COUNT_EN adds per-channel spike counters on
// bus.spike_count, cleared on frame accept.
module multi_rate_coder
  import snn_coder_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned W         = 16,
  parameter int unsigned T_STEPS   = 64,
  parameter logic [15:0] BASE_SEED = 16'h1705,
  parameter bit          INVERT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  multi_rate_coder_if.slave bus
);

  localparam int unsigned SW = $clog2(T_STEPS);

  state_t            state, state_n;
  logic [SW-1:0]     cnt;
  logic [N_CH*W-1:0] x_q;
  logic [N_CH-1:0]   hit;
  logic              run, accept;

  logic [N_CH-1:0]   spikes_q;
  logic              spike_valid_q;
  logic              done_q;
  logic [SW-1:0]     step_q;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    run     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cnt == SW'(T_STEPS - 1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      x_q           <= '0;
      spikes_q      <= '0;
      spike_valid_q <= 1'b0;
      done_q        <= 1'b0;
      step_q        <= '0;
    end else begin
      spike_valid_q <= run;
      done_q        <= (state == DONE);
      if (accept) begin
        x_q <= bus.in_data;
        cnt <= '0;
      end
      if (run) begin
        spikes_q <= hit;
        step_q   <= cnt;
        cnt      <= cnt + SW'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [15:0] q;

    lfsr16 #(.SEED(chan_seed(BASE_SEED, i))) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (run),
      .q   (q)
    );

    // x > q[15 -: W] is evaluated as (x << (16-W)) > q: identical result,
    // and every LFSR bit takes part in the compare.
    assign hit[i] = ((16'(x_q[i*W +: W]) << (LFSR_W - W)) > q) ^ INVERT;
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.spikes      = spikes_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.step_idx    = step_q;
  assign bus.done        = done_q;

`ifdef MULTI_RATE_CODER_SPIKE_COUNT_EN
  localparam int unsigned CW = $clog2(T_STEPS + 1);
  logic [N_CH*CW-1:0] sc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (accept)
          sc_q[i*CW +: CW] <= '0;
        else if (run && hit[i])
          sc_q[i*CW +: CW] <= sc_q[i*CW +: CW] + CW'(1);
      end
    end
  end

  assign bus.spike_count = sc_q;
`endif

endmodule

// File: tb/tb_multi_rate_coder.sv
// Directed bench for multi_rate_coder. Four instances share clk/rst:
// dut0 (W=16,T=64), dut1 (INVERT=1), dut2 (T=1024), dut3 (W=8).
// Expected spikes come from an independent LFSR reference model.
module tb_multi_rate_coder;
  import snn_coder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  multi_rate_coder_if #(.N_CH(4), .W(16), .T_STEPS(64))   if0 ();
  multi_rate_coder_if #(.N_CH(4), .W(16), .T_STEPS(64))   if1 ();
  multi_rate_coder_if #(.N_CH(4), .W(16), .T_STEPS(1024)) if2 ();
  multi_rate_coder_if #(.N_CH(4), .W(8),  .T_STEPS(64))   if3 ();

  multi_rate_coder #(.N_CH(4), .W(16), .T_STEPS(64), .BASE_SEED(16'h1705), .INVERT(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  multi_rate_coder #(.N_CH(4), .W(16), .T_STEPS(64), .BASE_SEED(16'h1705), .INVERT(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  multi_rate_coder #(.N_CH(4), .W(16), .T_STEPS(1024), .BASE_SEED(16'h1705), .INVERT(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  multi_rate_coder #(.N_CH(4), .W(8), .T_STEPS(64), .BASE_SEED(16'h1705), .INVERT(1'b0))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  int unsigned W_of [4] = '{16, 16, 16, 8};
  int unsigned T_of [4] = '{64, 64, 1024, 64};
  bit          INV_of [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int          sel = 0;
  logic [3:0]  o_spk;
  logic        o_sv, o_done, o_rdy;
  logic [9:0]  o_step;

  always_comb begin
    o_spk = '0; o_sv = 1'b0; o_done = 1'b0; o_rdy = 1'b0; o_step = '0;
    case (sel)
      0: begin o_spk = if0.spikes; o_sv = if0.spike_valid; o_done = if0.done;
               o_rdy = if0.in_ready; o_step = 10'(if0.step_idx); end
      1: begin o_spk = if1.spikes; o_sv = if1.spike_valid; o_done = if1.done;
               o_rdy = if1.in_ready; o_step = 10'(if1.step_idx); end
      2: begin o_spk = if2.spikes; o_sv = if2.spike_valid; o_done = if2.done;
               o_rdy = if2.in_ready; o_step = if2.step_idx; end
      default: begin o_spk = if3.spikes; o_sv = if3.spike_valid; o_done = if3.done;
               o_rdy = if3.in_ready; o_step = 10'(if3.step_idx); end
    endcase
  end

  logic [15:0] frame [4];
  logic [15:0] m [4][4];
  logic [3:0]  rec [1024];
  logic [3:0]  rec0 [20];
  int          cnt [4];

  function automatic logic [15:0] seed_of(input int i);
    logic [31:0] p;
    logic [15:0] s;
    p = i * 32'h0000_9E37;
    s = 16'h1705 ^ p[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] step_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++)
        m[d][c] = seed_of(c);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic v);
    case (s)
      0: begin if0.in_data = {frame[3], frame[2], frame[1], frame[0]}; if0.in_valid = v; end
      1: begin if1.in_data = {frame[3], frame[2], frame[1], frame[0]}; if1.in_valid = v; end
      2: begin if2.in_data = {frame[3], frame[2], frame[1], frame[0]}; if2.in_valid = v; end
      default: begin
        if3.in_data = {frame[3][7:0], frame[2][7:0], frame[1][7:0], frame[0][7:0]};
        if3.in_valid = v;
      end
    endcase
  endtask

  // Runs one window on instance s and checks every cycle against the model.
  // stop_at >= 0 returns right after observing that step (window left running).
  task automatic run_window(input int s, input int stop_at);
    int unsigned w, t;
    logic [15:0] x, r;
    logic [3:0]  exp;
    sel = s;
    w = W_of[s];
    t = T_of[s];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    @(negedge clk);
    drive(s, 1'b1);
    #1 check("ready_before_accept", 64'(o_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0);
    check("ready_in_run", 64'(o_rdy), 64'd0);
    check("valid_after_accept", 64'(o_sv), 64'd0);
    for (int k = 0; k < int'(t); k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        x = frame[c] & 16'((32'h1 << w) - 1);
        r = m[s][c] >> (16 - w);
        exp[c] = (x > r) ^ INV_of[s];
        m[s][c] = step_lfsr(m[s][c]);
      end
      check("spike_valid", 64'(o_sv), 64'd1);
      check("step_idx", 64'(o_step), 64'(k));
      check("spikes", 64'(o_spk), 64'(exp));
      check("done_in_run", 64'(o_done), 64'd0);
      check("ready_in_run", 64'(o_rdy), 64'd0);
      rec[k] = o_spk;
      for (int c = 0; c < 4; c++) cnt[c] += int'(o_spk[c]);
      if (k == stop_at) return;
    end
    @(negedge clk);
    check("valid_at_done", 64'(o_sv), 64'd0);
    check("done_pulse", 64'(o_done), 64'd1);
    check("ready_back", 64'(o_rdy), 64'd1);
    @(negedge clk);
    check("done_single", 64'(o_done), 64'd0);
    check("spikes_held", 64'(o_spk), 64'(rec[t-1]));
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if2.in_valid = 1'b0; if2.in_data = '0;
    if3.in_valid = 1'b0; if3.in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state on every instance.
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_ready", 64'(o_rdy), 64'd1);
      check("rst_valid", 64'(o_sv), 64'd0);
      check("rst_spikes", 64'(o_spk), 64'd0);
      check("rst_step", 64'(o_step), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
    end
    check("lfsr0_seed", 64'(dut0.g_ch[0].u_lfsr.q), 64'h1705);
    check("lfsr1_seed", 64'(dut0.g_ch[1].u_lfsr.q), 64'(chan_seed(16'h1705, 1)));
    check("lfsr1_model", 64'(dut0.g_ch[1].u_lfsr.q), 64'(seed_of(1)));

    // Full-scale frame.
    for (int c = 0; c < 4; c++) frame[c] = 16'hFFFF;
    run_window(0, -1);

    // Zero frame, normal and inverted.
    for (int c = 0; c < 4; c++) frame[c] = 16'h0000;
    run_window(0, -1);
    check("zero_total", 64'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 64'd0);
    run_window(1, -1);
    check("inv_total", 64'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 64'd256);

    // Half-scale rate over a long window.
    frame[0] = 16'h8000; frame[1] = 16'h1234; frame[2] = 16'hC000; frame[3] = 16'h4000;
    run_window(2, -1);
    check("half_rate_range", 64'(cnt[0] >= 448 && cnt[0] <= 576), 64'd1);

    // 8-bit intensities.
    frame[0] = 16'h0000; frame[1] = 16'h00FF; frame[2] = 16'h0040; frame[3] = 16'h00C0;
    run_window(3, -1);
    check("w8_ch0_zero", 64'(cnt[0]), 64'd0);
`ifdef MULTI_RATE_CODER_SPIKE_COUNT_EN
    for (int c = 0; c < 4; c++)
      check("spike_count", 64'(if3.spike_count[c*7 +: 7]), 64'(cnt[c]));
    check("spike_count_ch0", 64'(if3.spike_count[6:0]), 64'd0);
`endif

    // Reset mid-window, then replay from a clean reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    frame[0] = 16'h1111; frame[1] = 16'h9000; frame[2] = 16'h5555; frame[3] = 16'hEEEE;
    run_window(0, 20);
    for (int k = 0; k < 20; k++) rec0[k] = rec[k];
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(o_sv), 64'd0);
    check("midrst_spikes", 64'(o_spk), 64'd0);
    check("midrst_step", 64'(o_step), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    check("midrst_ready", 64'(o_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(o_done), 64'd0);
    end
    run_window(0, -1);
    for (int k = 0; k < 20; k++)
      check("replay", 64'(rec[k]), 64'(rec0[k]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
